// File: rtl/taus113_pkg.sv
// Shared constants, state types and the Tausworthe-113 step function used by
// the multi-lane generator and its lanes.
package taus113_pkg;

   typedef enum logic [1:0] {
      ST_EXPAND,
      ST_WARM,
      ST_RUN
   } fsm_state_e;

   // z1 sits in the low word so the layout reads naturally in waveforms.
   typedef struct packed {
      logic [31:0] z4;
      logic [31:0] z3;
      logic [31:0] z2;
      logic [31:0] z1;
   } taus_state_t;

   localparam logic [31:0] LCG_MUL = 32'd69069;
   localparam logic [31:0] LCG_INC = 32'd1;

   localparam logic [31:0] MIN_Z1 = 32'd1;
   localparam logic [31:0] MIN_Z2 = 32'd7;
   localparam logic [31:0] MIN_Z3 = 32'd15;
   localparam logic [31:0] MIN_Z4 = 32'd127;

   localparam logic [31:0] MASK_Z1 = 32'hFFFF_FFFE;
   localparam logic [31:0] MASK_Z2 = 32'hFFFF_FFF8;
   localparam logic [31:0] MASK_Z3 = 32'hFFFF_FFF0;
   localparam logic [31:0] MASK_Z4 = 32'hFFFF_FF80;

   localparam int Q_Z1 = 6;  localparam int S_Z1 = 13; localparam int K_Z1 = 18;
   localparam int Q_Z2 = 2;  localparam int S_Z2 = 27; localparam int K_Z2 = 2;
   localparam int Q_Z3 = 13; localparam int S_Z3 = 21; localparam int K_Z3 = 7;
   localparam int Q_Z4 = 3;  localparam int S_Z4 = 12; localparam int K_Z4 = 13;

   function automatic logic [31:0] comp_step(input logic [31:0] z, input logic [31:0] mask,
                                             input int q, input int s, input int k);
      return ((z & mask) << k) ^ (((z << q) ^ z) >> s);
   endfunction

   function automatic taus_state_t taus_step(input taus_state_t st);
      taus_state_t nx;
      nx.z1 = comp_step(st.z1, MASK_Z1, Q_Z1, S_Z1, K_Z1);
      nx.z2 = comp_step(st.z2, MASK_Z2, Q_Z2, S_Z2, K_Z2);
      nx.z3 = comp_step(st.z3, MASK_Z3, Q_Z3, S_Z3, K_Z3);
      nx.z4 = comp_step(st.z4, MASK_Z4, Q_Z4, S_Z4, K_Z4);
      return nx;
   endfunction

   // Words at or below a component's minimum would collapse that LFSR; lift them clear.
   function automatic logic [31:0] seed_fixup(input logic [31:0] x, input logic [1:0] comp);
      logic [31:0] min_k;
      case (comp)
         2'd0:    min_k = MIN_Z1;
         2'd1:    min_k = MIN_Z2;
         2'd2:    min_k = MIN_Z3;
         default: min_k = MIN_Z4;
      endcase
      return (x <= min_k) ? (x + min_k + 32'd1) : x;
   endfunction

endpackage

// File: rtl/taus113_lane.sv
// One Tausworthe-113 lane: four component registers, a word-load port for
// seeding and a step enable. Output is the XOR of the registered components.
module taus113_lane
   import taus113_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load_en,
   input  logic [1:0]  comp_sel,
   input  logic [31:0] load_word,
   input  logic        step_en,
   output logic [31:0] rnd_word
);

   taus_state_t state_q, state_d;

   // NOTE: next state is built with blocking assignments in always_comb, after a full default.
   always_comb begin
      state_d = state_q;
      if (load_en) begin
         case (comp_sel)
            2'd0:    state_d.z1 = load_word;
            2'd1:    state_d.z2 = load_word;
            2'd2:    state_d.z3 = load_word;
            default: state_d.z4 = load_word;
         endcase
      end else if (step_en) begin
         state_d = taus_step(state_q);
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (rst) state_q <= '0;
      else     state_q <= state_d;
   end

   assign rnd_word = state_q.z1 ^ state_q.z2 ^ state_q.z3 ^ state_q.z4;

endmodule

// File: rtl/taus113_multi.sv
// NUM_CH Tausworthe-113 lanes seeded from one 32-bit seed through an LCG chain,
// warmed up, then streamed behind a valid/ready handshake.
module taus113_multi
   import taus113_pkg::*;
#(
   parameter int          NUM_CH       = 4,
   parameter int          WARMUP       = 10,
   parameter logic [31:0] DEFAULT_SEED = 32'h1234_5678
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [31:0]           seed,
   input  logic                  re_seed,
   output logic                  busy,
   output logic                  rnd_valid,
   input  logic                  rnd_ready,
   output logic [32*NUM_CH-1:0]  rnd
);

   // One spare bit keeps the lane-select slice non-empty when NUM_CH=1.
   localparam int IDX_W  = $clog2(4 * NUM_CH) + 1;
   localparam int WCNT_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;
   localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(4 * NUM_CH - 1);
   localparam logic [WCNT_W-1:0] LAST_WCNT  = WCNT_W'((WARMUP > 0) ? WARMUP - 1 : 0);
   localparam fsm_state_e        POST_EXPAND = (WARMUP == 0) ? ST_RUN : ST_WARM;

   fsm_state_e        state_q, state_d;
   logic [31:0]       seed_q, seed_d;
   logic [31:0]       lcg_q, lcg_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [WCNT_W-1:0] wcnt_q, wcnt_d;
   logic              rnd_valid_q, rnd_valid_d;
   logic              busy_q, busy_d;

   logic        load_active;
   logic [31:0] load_word;
   logic        step_all;
   logic [31:0] x_cur, x_next;

   always_comb begin
      state_d     = state_q;
      seed_d      = seed_q;
      lcg_d       = lcg_q;
      idx_d       = idx_q;
      wcnt_d      = wcnt_q;
      load_active = 1'b0;
      load_word   = '0;
      step_all    = 1'b0;
      // The chain restarts from the sampled seed at the first expansion word.
      x_cur       = (idx_q == '0) ? seed_q : lcg_q;
      x_next      = x_cur * LCG_MUL + LCG_INC;

      if (re_seed) begin
         state_d = ST_EXPAND;
         seed_d  = seed;
         idx_d   = '0;
         wcnt_d  = '0;
      end else begin
         case (state_q)
            ST_EXPAND: begin
               load_active = 1'b1;
               load_word   = seed_fixup(x_next, idx_q[1:0]);
               lcg_d       = x_next;
               if (idx_q == LAST_IDX) begin
                  idx_d   = '0;
                  wcnt_d  = '0;
                  state_d = POST_EXPAND;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
            ST_WARM: begin
               step_all = 1'b1;
               if (wcnt_q == LAST_WCNT) state_d = ST_RUN;
               else                     wcnt_d  = wcnt_q + WCNT_W'(1);
            end
            default: begin
               step_all = rnd_valid_q && rnd_ready;
            end
         endcase
      end

      rnd_valid_d = (state_d == ST_RUN);
      busy_d      = (state_d != ST_RUN);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_EXPAND;
         seed_q      <= DEFAULT_SEED;
         lcg_q       <= '0;
         idx_q       <= '0;
         wcnt_q      <= '0;
         rnd_valid_q <= 1'b0;
         busy_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         seed_q      <= seed_d;
         lcg_q       <= lcg_d;
         idx_q       <= idx_d;
         wcnt_q      <= wcnt_d;
         rnd_valid_q <= rnd_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign busy      = busy_q;
   assign rnd_valid = rnd_valid_q;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
      logic lane_load;
      assign lane_load = load_active && (idx_q[IDX_W-1:2] == (IDX_W-2)'(c));

      taus113_lane u_lane (
         .clk       (clk),
         .rst       (rst),
         .load_en   (lane_load),
         .comp_sel  (idx_q[1:0]),
         .load_word (load_word),
         .step_en   (step_all),
         .rnd_word  (rnd[32*c +: 32])
      );
   end

endmodule
